// File: rtl/load_store_unit.sv
// RV32I load/store memory stage: one word-aligned req/ack transaction per access with byte enables and load extension.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN (default: force natural alignment).
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  err,
    output logic                  misaligned
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                  state, state_next;
    logic [2:0]              lat_funct3, lat_funct3_next;
    logic [1:0]              lat_offset, lat_offset_next;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_next;

    logic                    req_next, we_next, busy_next, done_next, err_next, mis_next;
    logic [DATA_WIDTH-1:0]   addr_next, wdata_next, rdata_next;
    logic [3:0]              be_next;

    logic [1:0]              size;
    logic                    f3_legal, illegal, trap;
    logic [1:0]              offset_c;
    logic [3:0]              be_c;
    logic [DATA_WIDTH-1:0]   wdata_c;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_data;

    assign size = Funct3[1:0];

    // Request decode from the execute-stage inputs
    always_comb begin
        f3_legal = 1'b0;
        offset_c = 2'b00;
        be_c     = 4'b1111;
        wdata_c  = WriteData;
        if (MemWrite)
            f3_legal = Funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_legal = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (size)
            2'b00: begin
                offset_c = ALUResult[1:0];
                be_c     = 4'b0001 << ALUResult[1:0];
                wdata_c  = {4{WriteData[7:0]}};
            end
            2'b01: begin
                offset_c = {ALUResult[1], 1'b0};
                be_c     = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{WriteData[15:0]}};
            end
            default: begin
                offset_c = 2'b00;
                be_c     = 4'b1111;
                wdata_c  = WriteData;
            end
        endcase
    end

    assign illegal = (MemRead & MemWrite) | ~f3_legal;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((size == 2'b01) & ALUResult[0]) | ((size == 2'b10) & (ALUResult[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Load lane select and extension from the latched size/offset
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lat_offset)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lat_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_funct3)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = DATA_WIDTH'(byte_sel);
            3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = DATA_WIDTH'(half_sel);
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_next      = state;
        req_next        = 1'b0;
        err_next        = 1'b0;
        mis_next        = 1'b0;
        we_next         = mem_we;
        addr_next       = mem_addr;
        be_next         = mem_be;
        wdata_next      = mem_wdata;
        rdata_next      = ReadData;
        lat_funct3_next = lat_funct3;
        lat_offset_next = lat_offset;
        wait_cnt_next   = wait_cnt;
        case (state)
            IDLE: begin
                if (start && (MemRead || MemWrite)) begin
                    if (illegal) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else if (trap) begin
                        state_next = DONE;
                        mis_next   = 1'b1;
                        rdata_next = '0;
                    end else begin
                        state_next      = REQ;
                        req_next        = 1'b1;
                        we_next         = MemWrite;
                        addr_next       = {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        be_next         = be_c;
                        wdata_next      = wdata_c;
                        lat_funct3_next = Funct3;
                        lat_offset_next = offset_c;
                        wait_cnt_next   = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next = DONE;
                    if (!mem_we)
                        rdata_next = load_data;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else begin
                    req_next      = 1'b1;
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        done_next = (state_next == DONE);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ReadData   <= '0;
            err        <= 1'b0;
            misaligned <= 1'b0;
            lat_funct3 <= '0;
            lat_offset <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_next;
            mem_req    <= req_next;
            mem_we     <= we_next;
            mem_addr   <= addr_next;
            mem_be     <= be_next;
            mem_wdata  <= wdata_next;
            busy       <= busy_next;
            done       <= done_next;
            ReadData   <= rdata_next;
            err        <= err_next;
            misaligned <= mis_next;
            lat_funct3 <= lat_funct3_next;
            lat_offset <= lat_offset_next;
            wait_cnt   <= wait_cnt_next;
        end
    end

endmodule
